// File: rtl/mips_pkg.sv
// Shared constants and control encodings for the MIPS fetch front end.
package mips_pkg;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam logic [31:0] RESET_PC     = 32'h0040_0000;
    localparam int unsigned MEMORY_DEPTH = 1024;
    localparam logic [31:0] NOP_INSTR    = 32'h0;
    localparam int unsigned PC_STEP      = 4;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_FLUSH
    } ifid_ctrl_e;
endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or flush to a nop bubble.
module if_id_register
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  ifid_ctrl_e            ctrl,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  valid
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr    <= DATA_WIDTH'(NOP_INSTR);
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else begin
            unique case (ctrl)
                IFID_LOAD: begin
                    instr    <= instr_in;
                    pc_plus4 <= pc_plus4_in;
                    valid    <= 1'b1;
                end
                IFID_FLUSH: begin
                    instr    <= DATA_WIDTH'(NOP_INSTR);
                    pc_plus4 <= '0;
                    valid    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, next-PC selection, fetch-window fault check and accepted-instruction counter.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned                   DATA_WIDTH   = mips_pkg::DATA_WIDTH,
    parameter logic        [DATA_WIDTH-1:0]  RESET_PC     = mips_pkg::RESET_PC,
    parameter int unsigned                   MEMORY_DEPTH = mips_pkg::MEMORY_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_valid_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] if_id_instruction_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                  if_id_valid_o,
    output logic                  fetch_fault_o,
    output logic [DATA_WIDTH-1:0] fetch_count_o
);

    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] WINDOW_END = RESET_PC + DATA_WIDTH'(PC_STEP * MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  in_window;
    logic                  fault;
    logic                  fault_next;
    logic                  count_inc;
    logic [DATA_WIDTH-1:0] count;
    ifid_ctrl_e            ifid_ctrl;

    assign pc_plus4  = pc + STEP;
    assign in_window = (pc >= RESET_PC) && (pc < WINDOW_END);

    // A faulted stage ignores stall/redirect; the IF/ID bubble was already written on the fault edge.
    always_comb begin
        pc_next    = pc;
        fault_next = fault;
        count_inc  = 1'b0;
        ifid_ctrl  = IFID_HOLD;
        if (!fault) begin
            if (redirect_valid_i) begin
                ifid_ctrl = IFID_FLUSH;
                if (redirect_target_i[1:0] != 2'b00) begin
                    fault_next = 1'b1;
                end else begin
                    pc_next = redirect_target_i;
                end
            end else if (!stall_i) begin
                if (!in_window) begin
                    fault_next = 1'b1;
                    ifid_ctrl  = IFID_FLUSH;
                end else begin
                    pc_next   = pc_plus4;
                    ifid_ctrl = IFID_LOAD;
                    count_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
            count <= '0;
        end else begin
            pc    <= pc_next;
            fault <= fault_next;
            if (count_inc && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

    if_id_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id_register (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (ifid_ctrl),
        .instr_in    (instruction_i),
        .pc_plus4_in (pc_plus4),
        .instr       (if_id_instruction_o),
        .pc_plus4    (if_id_pc_plus4_o),
        .valid       (if_id_valid_o)
    );

    assign pc_o          = pc;
    assign fetch_fault_o = fault;
    assign fetch_count_o = count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational ascending-word ROM.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic [31:0] instruction_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_instruction_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    // ROM word at byte address A is 0x1000_0000 + word index relative to the text base.
    assign instruction_i = 32'h1000_0000 + ((pc_o - 32'h0040_0000) >> 2);

    instruction_fetch_stage #(
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0040_0000),
        .MEMORY_DEPTH (1024)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_i             (stall_i),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_target_i   (redirect_target_i),
        .instruction_i       (instruction_i),
        .pc_o                (pc_o),
        .if_id_instruction_o (if_id_instruction_o),
        .if_id_pc_plus4_o    (if_id_pc_plus4_o),
        .if_id_valid_o       (if_id_valid_o),
        .fetch_fault_o       (fetch_fault_o),
        .fetch_count_o       (fetch_count_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic fault,
                             input logic [31:0] count);
        check({tag, ".pc"},    pc_o, pc);
        check({tag, ".instr"}, if_id_instruction_o, instr);
        check({tag, ".pc4"},   if_id_pc_plus4_o, pc4);
        check({tag, ".valid"}, {31'b0, if_id_valid_o}, {31'b0, valid});
        check({tag, ".fault"}, {31'b0, fetch_fault_o}, {31'b0, fault});
        check({tag, ".count"}, fetch_count_o, count);
    endtask

    initial begin
        reset             = 1'b0;
        stall_i           = 1'b0;
        redirect_valid_i  = 1'b0;
        redirect_target_i = '0;

        step();
        check_all("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;

        // Free run: edge k fetches word k-1
        for (int k = 1; k <= 4; k++) begin
            step();
            check_all($sformatf("run%0d", k), 32'h0040_0000 + 32'(4 * k),
                      32'h1000_0000 + 32'(k - 1), 32'h0040_0000 + 32'(4 * k),
                      1'b1, 1'b0, 32'(k));
        end

        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all($sformatf("stall%0d", k), 32'h0040_0010, 32'h1000_0003, 32'h0040_0010,
                      1'b1, 1'b0, 32'd4);
        end
        stall_i = 1'b0;
        step();
        check_all("release", 32'h0040_0014, 32'h1000_0004, 32'h0040_0014, 1'b1, 1'b0, 32'd5);

        // Redirect beats stall on the same edge
        stall_i           = 1'b1;
        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'h0040_0040;
        step();
        check_all("redir_stall", 32'h0040_0040, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        step();
        check_all("redir_fetch", 32'h0040_0044, 32'h1000_0010, 32'h0040_0044, 1'b1, 1'b0, 32'd6);

        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'h0040_0044;
        step();
        check_all("redir_self", 32'h0040_0044, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
        redirect_valid_i = 1'b0;
        step();
        check_all("refetch", 32'h0040_0048, 32'h1000_0011, 32'h0040_0048, 1'b1, 1'b0, 32'd7);

        // Misaligned target faults; later redirects and steps are ignored
        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'h0040_0042;
        step();
        check_all("misalign", 32'h0040_0048, 32'h0, 32'h0, 1'b0, 1'b1, 32'd7);
        redirect_target_i = 32'h0040_0100;
        step();
        check_all("fault_redir", 32'h0040_0048, 32'h0, 32'h0, 1'b0, 1'b1, 32'd7);
        redirect_valid_i = 1'b0;
        step();
        check_all("fault_step", 32'h0040_0048, 32'h0, 32'h0, 1'b0, 1'b1, 32'd7);

        reset = 1'b0;
        step();
        check_all("fault_clr", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;

        // Sequential run to the top of the window
        for (int k = 0; k < 1023; k++) step();
        check_all("top_m1", 32'h0040_0FFC, 32'h1000_03FE, 32'h0040_0FFC, 1'b1, 1'b0, 32'd1023);
        step();
        check_all("top", 32'h0040_1000, 32'h1000_03FF, 32'h0040_1000, 1'b1, 1'b0, 32'd1024);
        stall_i = 1'b1;
        step();
        check_all("top_stall", 32'h0040_1000, 32'h1000_03FF, 32'h0040_1000, 1'b1, 1'b0, 32'd1024);
        stall_i = 1'b0;
        step();
        check_all("window", 32'h0040_1000, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1024);

        // Reset during stall
        reset   = 1'b0;
        stall_i = 1'b1;
        step();
        check_all("rst_stall", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset   = 1'b1;
        stall_i = 1'b0;

        // Aligned redirect far outside the window is accepted, fetching from it faults
        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'hFFFF_FFFC;
        step();
        check_all("wrap_redir", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        redirect_valid_i = 1'b0;
        step();
        check_all("wrap_fault", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);

        // Reset during redirect
        reset             = 1'b0;
        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'h0040_0080;
        step();
        check_all("rst_redir", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset            = 1'b1;
        redirect_valid_i = 1'b0;
        step();
        check_all("post_rst", 32'h0040_0004, 32'h1000_0000, 32'h0040_0004, 1'b1, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
